// File: rtl/int_to_float_if.sv
// int_to_float request/result bus.
// Start_Sig/Done_Sig handshake shared with the adder.
interface int_to_float_if;
  logic        Start_Sig;
  logic [31:0] A;
  logic [31:0] Result;
  logic [3:0]  Done_Sig;

  modport master (
    output Start_Sig,
    output A,
    input  Result,
    input  Done_Sig
  );

  modport slave (
    input  Start_Sig,
    input  A,
    output Result,
    output Done_Sig
  );
endinterface

// File: rtl/int_to_float.sv
// int32 -> binary32 converter, round to nearest-even.
// Define INT2FLOAT_LZC_EN for single-cycle leading-zero normalize.
module int_to_float #(
  parameter bit SIGNED = 1'b1
) (
  input logic           clk,
  input logic           rst,
  int_to_float_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_NORM    = 3'd1;
  localparam logic [2:0] S_ROUND   = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [2:0]  state_q;
  logic [31:0] mag_q;
  logic [7:0]  exp_q;
  logic        sign_q;
  logic [31:0] result_q;
  logic        done_q;
  logic        inexact_q;
  logic        zero_q;

  logic        sgn_in;
  logic [31:0] mag_in;
  logic [22:0] frac;
  logic        guard;
  logic        sticky;
  logic        inc;
  logic [23:0] frac_sum;
  logic [7:0]  exp_rnd;
  logic        mag_zero;

  assign sgn_in   = SIGNED & bus.A[31];
  assign mag_in   = sgn_in ? (~bus.A + 32'd1) : bus.A;
  assign mag_zero = (mag_q == 32'd0);

  assign frac     = mag_q[30:8];
  assign guard    = mag_q[7];
  assign sticky   = |mag_q[6:0];
  assign inc      = guard & (sticky | frac[0]);
  assign frac_sum = {1'b0, frac} + {23'd0, inc};
  assign exp_rnd  = exp_q + {7'd0, frac_sum[23]};

`ifdef INT2FLOAT_LZC_EN
  function automatic logic [5:0] clz(input logic [31:0] v);
    clz = 6'd32;
    for (int i = 0; i < 32; i++)
      if (v[i]) clz = 6'(31 - i);
  endfunction

  logic [5:0] lz;
  assign lz = clz(mag_q);
`endif

  // Conversion FSM: capture, normalize, round, pulse done, await release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mag_q     <= '0;
      exp_q     <= '0;
      sign_q    <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      inexact_q <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.Start_Sig) begin
            sign_q  <= sgn_in;
            mag_q   <= mag_in;
            exp_q   <= 8'd158;
            state_q <= S_NORM;
          end
        end
        S_NORM: begin
`ifdef INT2FLOAT_LZC_EN
          if (!mag_zero) begin
            mag_q <= mag_q << lz[4:0];
            exp_q <= 8'd158 - {2'b00, lz};
          end
          state_q <= S_ROUND;
`else
          if (mag_zero || mag_q[31]) begin
            state_q <= S_ROUND;
          end else begin
            mag_q <= {mag_q[30:0], 1'b0};
            exp_q <= exp_q - 8'd1;
          end
`endif
        end
        S_ROUND: begin
          result_q  <= mag_zero ? 32'd0
                     : {sign_q, exp_rnd, frac_sum[22:0]};
          zero_q    <= mag_zero;
          inexact_q <= guard | sticky;
          done_q    <= 1'b1;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!bus.Start_Sig) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.Result   = result_q;
  assign bus.Done_Sig = {1'b0, zero_q, inexact_q, done_q};

endmodule
